nios_oci_trace_packer: RTL
==========================

// Module: nios_oci_trace_packer
// PURPOSE
//  Parametrised trace-capture packer for the CPU on-chip-instrumentation (OCI) debug path.
//  Collects ENTRY_W-bit trace fragments into a DEPTH-entry packing buffer and exposes the live buffer and count.
//  Seals full or flushed buffers into a one-deep output slot with a valid/ready handshake.
//  Runs an end-of-test drain sequence that ends in a sticky test_has_ended.
//  Sits between the OCI trace source and the trace FIFO / sim monitor.
// PARAMETERS
//  ENTRY_W        2   width of one trace fragment
//  DEPTH          15  fragments per packed word (DEPTH >= 2)
//  CNT_W          4   count width; must satisfy 2**CNT_W > DEPTH
//  STALL_ON_FULL  1   1: back-pressure the source when full; 0: drop fragments and count overflows
// PORTS
//  clk            in   1                 single clock, rising edge
//  reset_n        in   1                 asynchronous, active-low reset
//  trc_valid      in   1                 trace fragment valid
//  trc_data       in   ENTRY_W           trace fragment
//  trc_ready      out  1                 fragment accepted when trc_valid & trc_ready
//  flush          in   1                 seal a partial buffer (level, sampled each clk)
//  test_ending    in   1                 request end-of-test drain
//  test_has_ended out  1                 sticky; drain complete
//  dct_buffer     out  DEPTH*ENTRY_W     live packing buffer
//  dct_count      out  CNT_W             fragments held in dct_buffer
//  out_valid      out  1                 packed word available
//  out_data       out  DEPTH*ENTRY_W     packed word
//  out_count      out  CNT_W             valid fragments in out_data
//  out_ready      in   1                 consumer takes the word when out_valid & out_ready
//  ovf_count      out  16                dropped fragments, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - All registered outputs are 0; state is RUN.
//   - trc_ready is forced to 0 while reset_n is low.
//  States: RUN -> DRAIN -> DONE.
//   - RUN -> DRAIN on the first clk with test_ending=1.
//   - DRAIN -> DONE when dct_count==0 and out_valid==0.
//   - DONE is held until reset.
//  Accept (RUN only):
//   - dct_buffer <= {dct_buffer[DEPTH*ENTRY_W-ENTRY_W-1:0], trc_data}; dct_count++.
//   - The newest fragment sits in the LSBs; unused upper bits are 0.
//  slot_free = !out_valid | out_ready
//  seal = slot_free & (dct_count==DEPTH | (flush & dct_count!=0) | (DRAIN & dct_count!=0))
//  On seal, at the clock edge:
//   - out_data <= dct_buffer; out_count <= dct_count; out_valid <= 1.
//   - dct_buffer and dct_count clear.
//   - A fragment accepted in the same cycle becomes entry 0 of the fresh buffer (dct_count=1).
//  Output handshake:
//   - out_valid drops after out_valid & out_ready, unless a new seal happens in the same cycle (back-to-back allowed).
//   - out_data and out_count stay stable while out_valid & !out_ready.
//  trc_ready:
//   - STALL_ON_FULL=1: trc_ready = RUN & (dct_count<DEPTH | slot_free).
//   - STALL_ON_FULL=0: trc_ready = RUN.
//   - STALL_ON_FULL=0 with dct_count==DEPTH and !slot_free: the fragment is dropped, the buffer is unchanged, ovf_count increments (saturating).
//  End of test:
//   - trc_ready=0 in DRAIN and DONE.
//   - A fragment presented with test_ending in the same RUN cycle is still accepted.
//   - flush is ignored outside RUN.
//   - test_has_ended rises on the clk that enters DONE and stays high.
//   - test_ending deasserting during DRAIN has no effect.
//  Latency: full buffer or flush to out_valid = 1 clk when the slot is free.
//  Reset mid-operation: all contents are discarded and no partial word is emitted.
// TESTING
//  1. Defaults, out_ready=1; push 15 fragments of 2'b01 -> next clk out_valid=1, out_count=15, out_data=30'h15555555, dct_count=0.
//  2. Push 1,2,3 then pulse flush -> out_data=30'h0000001B, out_count=3, single-cycle out_valid.
//  3. STALL_ON_FULL=1, out_ready=0; push 30 -> trc_ready=0 with dct_count=15, out_count=15; raise out_ready -> slot reloads next clk, trc_ready=1.
//  4. STALL_ON_FULL=0, same as 3 but push 35 -> ovf_count=5, dct_buffer holds fragments 16..30.
//  5. dct_count=4, out_valid pending, raise test_ending -> trc_ready=0; word1 out, then word2 with out_count=4; test_has_ended=1 the clk after word2's handshake.
//  6. Assert reset_n=0 mid-DRAIN -> all outputs 0 immediately; after release, state RUN and trc_ready=1.

Source files
------------

// File: rtl/nios_oci_trace_packer_if.sv
// Trace packer bus: fragment stream in, packed-word stream out.
// The packer takes the slave side; the trace source/consumer takes the master side.
interface nios_oci_trace_packer_if #(
    parameter int ENTRY_W = 2,
    parameter int DEPTH   = 15,
    parameter int CNT_W   = 4
);
    logic                       trc_valid;
    logic [ENTRY_W-1:0]         trc_data;
    logic                       trc_ready;
    logic                       out_valid;
    logic [DEPTH*ENTRY_W-1:0]   out_data;
    logic [CNT_W-1:0]           out_count;
    logic                       out_ready;

    modport master (
        output trc_valid, trc_data, out_ready,
        input  trc_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  trc_valid, trc_data, out_ready,
        output trc_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/nios_oci_trace_packer.sv
// OCI trace packer: packs trace fragments into DEPTH-entry words.
// Each sealed word goes to a one-deep valid/ready slot. A drain sequence ends in a sticky test_has_ended.
module nios_oci_trace_packer #(
    parameter int ENTRY_W       = 2,
    parameter int DEPTH         = 15,
    parameter int CNT_W         = 4,
    parameter int STALL_ON_FULL = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    nios_oci_trace_packer_if.slave   bus,
    input  logic                     flush,
    input  logic                     test_ending,
    output logic                     test_has_ended,
    output logic [DEPTH*ENTRY_W-1:0] dct_buffer,
    output logic [CNT_W-1:0]         dct_count,
    output logic [15:0]              ovf_count
);
    localparam int               BUF_W   = DEPTH * ENTRY_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic             STALL_C = (STALL_ON_FULL != 0);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [BUF_W-1:0] dct_buffer_r;
    logic [CNT_W-1:0] dct_count_r;
    logic [BUF_W-1:0] out_data_r;
    logic [CNT_W-1:0] out_count_r;
    logic             out_valid_r;
    logic             test_has_ended_r;
    logic [15:0]      ovf_count_r;

    logic             is_run_s;
    logic             is_drain_s;
    logic             slot_free_s;
    logic             full_s;
    logic             has_data_s;
    logic             seal_s;
    logic             trc_ready_s;
    logic             accept_s;
    logic             drop_s;
    logic [BUF_W-1:0] shifted_s;
    logic [BUF_W-1:0] fresh_s;

    assign is_run_s    = (state_r == ST_RUN);
    assign is_drain_s  = (state_r == ST_DRAIN);
    assign slot_free_s = !out_valid_r | bus.out_ready;
    assign full_s      = (dct_count_r == DEPTH_C);
    assign has_data_s  = (dct_count_r != ZERO_C);
    // Flush only counts in RUN; DRAIN seals any partial buffer on its own.
    assign seal_s      = slot_free_s & (full_s | (flush & is_run_s & has_data_s) | (is_drain_s & has_data_s));
    assign trc_ready_s = reset_n & is_run_s & (!STALL_C | !full_s | slot_free_s);
    // A full buffer with a blocked slot drops the fragment (only reachable without stall).
    assign accept_s    = bus.trc_valid & trc_ready_s & (!full_s | slot_free_s);
    assign drop_s      = bus.trc_valid & trc_ready_s & full_s & !slot_free_s;
    assign shifted_s   = {dct_buffer_r[BUF_W-ENTRY_W-1:0], bus.trc_data};
    assign fresh_s     = {{(BUF_W-ENTRY_W){1'b0}}, bus.trc_data};

    assign bus.trc_ready  = trc_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_data   = out_data_r;
    assign bus.out_count  = out_count_r;
    assign test_has_ended = test_has_ended_r;
    assign dct_buffer     = dct_buffer_r;
    assign dct_count      = dct_count_r;
    assign ovf_count      = ovf_count_r;

    // Packing buffer and output slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dct_buffer_r <= {BUF_W{1'b0}};
            dct_count_r  <= ZERO_C;
            out_data_r   <= {BUF_W{1'b0}};
            out_count_r  <= ZERO_C;
            out_valid_r  <= 1'b0;
        end else if (seal_s) begin
            out_data_r  <= dct_buffer_r;
            out_count_r <= dct_count_r;
            out_valid_r <= 1'b1;
            if (accept_s) begin
                dct_buffer_r <= fresh_s;
                dct_count_r  <= ONE_C;
            end else begin
                dct_buffer_r <= {BUF_W{1'b0}};
                dct_count_r  <= ZERO_C;
            end
        end else begin
            if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            if (accept_s) begin
                dct_buffer_r <= shifted_s;
                dct_count_r  <= dct_count_r + ONE_C;
            end else begin
                dct_buffer_r <= dct_buffer_r;
                dct_count_r  <= dct_count_r;
            end
        end
    end

    // Saturating count of dropped fragments
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_count_r <= 16'd0;
        end else if (drop_s && (ovf_count_r != 16'hFFFF)) begin
            ovf_count_r <= ovf_count_r + 16'd1;
        end else begin
            ovf_count_r <= ovf_count_r;
        end
    end

    // End-of-test sequencing: RUN -> DRAIN -> DONE (sticky)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= ST_RUN;
            test_has_ended_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (test_ending) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (!has_data_s && !out_valid_r) begin
                        state_r          <= ST_DONE;
                        test_has_ended_r <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state_r          <= ST_DONE;
                    test_has_ended_r <= 1'b1;
                end
                default: begin
                    state_r          <= ST_RUN;
                    test_has_ended_r <= 1'b0;
                end
            endcase
        end
    end
endmodule
